// File: rtl/sphere_burst_ram.sv
// Sphere-record RAM: single-word host writes, NUM_LANES-word burst reads
// delivered as one wide word over a valid/ready handshake.
module sphere_burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int NUM_LANES  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            wr_done,
  output logic                            wr_err,
  input  logic                            clear,
  output logic [ADDR_WIDTH:0]             fill_count,
  output logic                            full,
  input  logic                            rd_req,
  input  logic [ADDR_WIDTH-1:0]           rd_base,
  output logic                            rd_busy,
  output logic                            rd_err,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] rd_data
);

  localparam int CW = $clog2(NUM_LANES + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LANES_W = (ADDR_WIDTH + 1)'(NUM_LANES);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);
  localparam logic [CW-1:0]       LAST    = CW'(NUM_LANES);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   lanes [NUM_LANES];
  logic [ADDR_WIDTH-1:0]   base;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           lane_idx;
  logic [ADDR_WIDTH:0]     wr_top;
  logic [ADDR_WIDTH:0]     req_end;
  logic                    wr_ok;
  logic                    req_ok;
  logic                    rd_en;
  logic                    cap_en;
  logic                    start;

  assign wr_ok    = wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign wr_top   = {1'b0, wr_addr} + ONE_W;
  // Computed one bit wider so a burst running past the top cannot wrap into range.
  assign req_end  = {1'b0, rd_base} + LANES_W;
  assign req_ok   = req_end <= fill_count;
  assign start    = (state == IDLE) && rd_req && req_ok;
  assign rd_en    = (state == FETCH) && (cnt != LAST);
  assign cap_en   = (state == FETCH) && (cnt != '0);
  assign lane_idx = cnt - CW'(1);
  assign rd_addr  = base + ADDR_WIDTH'(cnt);
  assign full     = (fill_count == DEPTH_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_done    <= 1'b0;
      wr_err     <= 1'b0;
      fill_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      wr_done <= wr_ok;
      wr_err  <= wr_en && !wr_ok;
      if (clear)
        fill_count <= '0;
      else if (wr_ok && (wr_top > fill_count))
        fill_count <= wr_top;
    end
  end

  // NOTE: the array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_word <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_next = state;
    rd_busy    = 1'b1;
    rd_valid   = 1'b0;
    case (state)
      IDLE: begin
        rd_busy = 1'b0;
        if (start)
          state_next = FETCH;
      end
      FETCH: begin
        if (cnt == LAST)
          state_next = HOLD;
      end
      HOLD: begin
        rd_valid = 1'b1;
        if (rd_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address i goes out while cnt == i; its word lands in lane i while cnt == i+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      base   <= '0;
      cnt    <= '0;
      rd_err <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++)
        lanes[k] <= '0;
    end else begin
      rd_err <= (state == IDLE) && rd_req && !req_ok;
      if (start) begin
        base <= rd_base;
        cnt  <= '0;
      end else if (rd_en) begin
        cnt <= cnt + CW'(1);
      end
      for (int k = 0; k < NUM_LANES; k++)
        if (cap_en && (lane_idx == CW'(k)))
          lanes[k] <= rd_word;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_LANES; k++)
      rd_data[k*DATA_WIDTH +: DATA_WIDTH] = lanes[k];
  end

endmodule

// File: doc/sphere_burst_ram.md
Name: sphere_burst_ram

Overview:
- Parametrised single-clock successor to the sphere-parameter RAM in the dCollideSpheres datapath.
- Host/JTAG side writes one word per cycle. Collision engine requests an NUM_LANES-word burst (one sphere record) from a base address and receives it as one wide word through a valid/ready handshake.
- Adds range checking, a fill counter with explicit clear, and a registered burst-read FSM for BRAM-friendly single-port reads.

Parameters:
DATA_WIDTH, 32, width of one memory word
ADDR_WIDTH, 5, address width; must satisfy 2**ADDR_WIDTH >= DEPTH
DEPTH, 32, number of words
NUM_LANES, 8, words returned per burst; 1 <= NUM_LANES <= DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_done  out  1  one-cycle pulse: write accepted
wr_err  out  1  one-cycle pulse: write rejected, wr_addr >= DEPTH
clear  in  1  reset fill_count to 0; memory contents untouched
fill_count  out  ADDR_WIDTH+1  highest written address + 1
full  out  1  fill_count == DEPTH
rd_req  in  1  burst request, sampled only in IDLE
rd_base  in  ADDR_WIDTH  first word address of the burst
rd_busy  out  1  FSM not in IDLE
rd_err  out  1  one-cycle pulse: request rejected as out of range
rd_valid  out  1  burst data valid
rd_ready  in  1  consumer accepts burst
rd_data  out  NUM_LANES*DATA_WIDTH  lane k = mem[base+k] at bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset: wr_done, wr_err, rd_err, rd_valid, rd_busy, full = 0; fill_count = 0; rd_data = 0; FSM = IDLE. Memory array is not cleared. Reset mid-burst aborts the burst immediately with no rd_valid.
- Write path:
  - On wr_en && wr_addr < DEPTH, mem[wr_addr] <= wr_data at the edge and wr_done = 1 for the following cycle.
  - On wr_en && wr_addr >= DEPTH, there is no write and wr_err = 1 for the following cycle.
  - Back-to-back writes pulse every cycle.
- fill_count:
  - On an accepted write, fill_count <= max(fill_count, wr_addr+1).
  - clear has priority over this update in the same cycle; a simultaneous write still stores its data.
  - full is combinational from fill_count.
- Range check: compute rd_base + NUM_LANES in ADDR_WIDTH+1 bits. The request is valid iff that sum <= fill_count. No wrap-around; bursts never cross DEPTH.
- FSM states IDLE, FETCH, HOLD:
  - IDLE: if rd_req && valid, latch base, clear lane index, go to FETCH. If rd_req && !valid, pulse rd_err next cycle and stay in IDLE.
  - FETCH: synchronous read, one word per cycle, 1-cycle read latency. Address base+i is issued in cycle i; its word is captured into lane i in cycle i+1. After lane NUM_LANES-1 is captured, go to HOLD.
  - HOLD: rd_valid = 1 and rd_data is stable. On rd_valid && rd_ready, go to IDLE and deassert rd_valid the next cycle. rd_data retains its value after leaving HOLD.
- Latency: rd_req sampled at edge E0 gives rd_valid high from edge E0+NUM_LANES+1. With rd_ready held high, rd_busy is high for NUM_LANES+2 cycles.
- rd_req while rd_busy is ignored; there is no queueing.
- Same-cycle write and read to the same address returns the old word. Writes to lanes already captured are not reflected in rd_data.
- rd_base is sampled only in IDLE; changes during a burst have no effect.

Test Plan:
(All with DATA_WIDTH=32, DEPTH=32, NUM_LANES=8.)
1. Reset, then write mem[i] = 32'hA000_0000+i for i=0..31 back-to-back -> wr_done high 32 consecutive cycles, fill_count=32, full=1, wr_err never.
2. rd_req with rd_base=8, rd_ready=1 -> rd_valid exactly 9 cycles after the request edge, lane k = 32'hA000_0008+k, rd_busy high 10 cycles.
3. rd_base=25 (25+8 > 32), and separately rd_base=4 after clear with fill_count=0 -> rd_err single pulse, rd_busy stays 0, rd_valid stays 0.
4. wr_en with wr_addr=31 (ADDR_WIDTH=5, DEPTH=31 variant), and a simultaneous clear+write to address 3 -> wr_err pulse with no write; fill_count=0 after clear, mem[3] updated.
5. Burst at base 0 with rd_ready low for 5 cycles, then high; toggle rd_base and rd_req meanwhile -> rd_data constant, second request ignored, rd_valid drops one cycle after the handshake.
6. Assert rst during FETCH lane 3 -> next cycle rd_busy=0, rd_valid=0, rd_data=0; a new burst afterwards completes normally.
